// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: state encodings shared by every pipeline stage register.
package pipe_stage_reg_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake, flush and stall count of one stage boundary.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: counter that increments on inc and sticks at its all-ones maximum.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  assign count_d = (inc && count_q != '1) ? count_q + CNT_W'(1) : count_q;
  assign count = count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, NOP bubbles and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave io
);
  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept, xfer;
  assign io.out_valid = state_q != ST_EMPTY;
  assign io.out_data  = data_q;
  assign accept       = io.in_valid && io.in_ready;
  assign xfer         = io.out_valid && io.out_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  assign io.in_ready = state_q != ST_FULL;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    if (io.flush) begin
      state_d = ST_EMPTY;
      data_d  = NOP_VALUE;
    end else if (accept && state_q == ST_ONE && !xfer) begin
      state_d = ST_FULL;
      skid_d  = io.in_data;
    end else if (accept) begin
      state_d = ST_ONE;
      data_d  = io.in_data;
    end else if (xfer) begin
      state_d = state_q == ST_FULL ? ST_ONE : ST_EMPTY;
      data_d  = state_q == ST_FULL ? skid_q : NOP_VALUE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) skid_q <= '0;
    else       skid_q <= skid_d;
  end
`else
  // Downstream ready frees the single slot in the same cycle.
  assign io.in_ready = !io.out_valid || io.out_ready;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (io.flush) begin
      state_d = ST_EMPTY;
      data_d  = NOP_VALUE;
    end else if (accept) begin
      state_d = ST_ONE;
      data_d  = io.in_data;
    end else if (xfer) begin
      state_d = ST_EMPTY;
      data_d  = NOP_VALUE;
    end
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (io.out_valid && !io.out_ready),
    .count (io.stall_cnt)
  );
endmodule
